// File: rtl/spi_sensor_link.sv
// SPI-slave link: receives NUM_CFG config words, then serves a latched DATA_W-bit channel MSB-first (SPI mode 0).
// Define SPI_SENSOR_LINK_PARITY_EN to append an even-parity bit to every output frame.
module spi_sensor_link #(
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 3,
  parameter int CFG_W   = 8,
  parameter int NUM_CFG = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [$clog2(NUM_CH)-1:0]  ch_sel,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic                       cfg_rearm,
  input  logic                       sclk,
  input  logic                       ss_n,
  input  logic                       mosi,
  output logic                       miso,
  output logic [NUM_CFG*CFG_W-1:0]   cfg_regs,
  output logic                       configured,
  output logic                       data_ready,
  output logic                       done,
  output logic                       abort
);

`ifdef SPI_SENSOR_LINK_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int CW = $clog2(CFG_W + 1);
  localparam int BW = $clog2(FRAME_W + 1);
  localparam int IW = $clog2(NUM_CFG + 1);
  localparam logic [CW-1:0] CFG_LAST   = CW'(CFG_W - 1);
  localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_W - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_CFG - 1);

  typedef enum logic [1:0] {CFG, IDLE, READY, SHIFT} state_t;

  state_t                     state, state_n;
  logic [2:0]                 sclk_q, ss_q, mosi_q;
  logic [IW-1:0]              idx, idx_n;
  logic [CFG_W-1:0]           cfg_sh, cfg_sh_n;
  logic [CW-1:0]              cfg_cnt, cfg_cnt_n;
  logic [NUM_CFG*CFG_W-1:0]   cfg_regs_n;
  logic                       configured_n, data_ready_n, done_n, abort_n;
  logic [FRAME_W-1:0]         sh, sh_n;
  logic [BW-1:0]              bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0]          sel_word;
  logic [FRAME_W-1:0]         load_word;
  logic [CFG_W-1:0]           cfg_word;
  logic                       ch_ok, sclk_rise, sclk_fall, ss_rise, mosi_s;

  // Index 0/1 form the synchroniser, index 2 is the history flop used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      ss_q   <= {ss_q[1:0], ss_n};
      mosi_q <= {mosi_q[1:0], mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2] & ~ss_q[1];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2] & ~ss_q[1];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  // MOSI taken one flop later than sclk so the sampled bit is safely older than the rising edge.
  assign mosi_s    = mosi_q[2];
  assign cfg_word  = {cfg_sh[CFG_W-2:0], mosi_s};
  assign ch_ok     = (32'(ch_sel) < NUM_CH);

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (32'(ch_sel) == i) sel_word = ch_data[i*DATA_W +: DATA_W];
  end

`ifdef SPI_SENSOR_LINK_PARITY_EN
  assign load_word = {sel_word, ^sel_word};
`else
  assign load_word = sel_word;
`endif

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cfg_sh_n     = cfg_sh;
    cfg_cnt_n    = cfg_cnt;
    cfg_regs_n   = cfg_regs;
    configured_n = configured;
    data_ready_n = data_ready;
    done_n       = 1'b0;
    abort_n      = 1'b0;
    sh_n         = sh;
    bit_cnt_n    = bit_cnt;
    if (cfg_rearm) begin
      state_n      = CFG;
      idx_n        = '0;
      cfg_cnt_n    = '0;
      configured_n = 1'b0;
      data_ready_n = 1'b0;
    end else begin
      case (state)
        CFG: begin
          if (ss_rise) begin
            if (cfg_cnt != '0) abort_n = 1'b1;
            cfg_cnt_n = '0;
          end else if (sclk_rise) begin
            cfg_sh_n = cfg_word;
            if (cfg_cnt == CFG_LAST) begin
              cfg_cnt_n = '0;
              for (int i = 0; i < NUM_CFG; i++)
                if (idx == IW'(i)) cfg_regs_n[i*CFG_W +: CFG_W] = cfg_word;
              if (idx == IDX_LAST) begin
                idx_n        = '0;
                configured_n = 1'b1;
                state_n      = IDLE;
              end else begin
                idx_n = idx + 1'b1;
              end
            end else begin
              cfg_cnt_n = cfg_cnt + 1'b1;
            end
          end
        end
        IDLE: begin
          if (load_en && ch_ok) begin
            sh_n         = load_word;
            bit_cnt_n    = '0;
            data_ready_n = 1'b1;
            state_n      = READY;
          end
        end
        READY: begin
          if (ss_rise) begin
            abort_n      = 1'b1;
            data_ready_n = 1'b0;
            state_n      = IDLE;
          end else if (sclk_rise) begin
            bit_cnt_n = BW'(1);
            state_n   = SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            abort_n      = 1'b1;
            data_ready_n = 1'b0;
            state_n      = IDLE;
          end else if (sclk_rise) begin
            if (bit_cnt == FRAME_LAST) begin
              done_n       = 1'b1;
              data_ready_n = 1'b0;
              bit_cnt_n    = '0;
              state_n      = IDLE;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            sh_n = {sh[FRAME_W-2:0], 1'b0};
          end
        end
        default: state_n = CFG;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CFG;
      idx        <= '0;
      cfg_sh     <= '0;
      cfg_cnt    <= '0;
      cfg_regs   <= '0;
      configured <= 1'b0;
      data_ready <= 1'b0;
      done       <= 1'b0;
      abort      <= 1'b0;
      sh         <= '0;
      bit_cnt    <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cfg_sh     <= cfg_sh_n;
      cfg_cnt    <= cfg_cnt_n;
      cfg_regs   <= cfg_regs_n;
      configured <= configured_n;
      data_ready <= data_ready_n;
      done       <= done_n;
      abort      <= abort_n;
      sh         <= sh_n;
      bit_cnt    <= bit_cnt_n;
    end
  end

  assign miso = (state == READY || state == SHIFT) ? sh[FRAME_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_sensor_link.sv
// Directed self-checking bench for spi_sensor_link; honours SPI_SENSOR_LINK_PARITY_EN for frame length.
module tb_spi_sensor_link;

`ifdef SPI_SENSOR_LINK_PARITY_EN
  localparam int FRAME = 17;
`else
  localparam int FRAME = 16;
`endif

  logic        clk, rst, load_en, cfg_rearm, sclk, ss_n, mosi;
  logic [1:0]  ch_sel;
  logic [47:0] ch_data;
  logic        miso, configured, data_ready, done, abort;
  logic [31:0] cfg_regs;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int both_cnt = 0;
  int done_side_bad = 0;

  spi_sensor_link dut (
    .clk(clk), .rst(rst), .load_en(load_en), .ch_sel(ch_sel), .ch_data(ch_data),
    .cfg_rearm(cfg_rearm), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .cfg_regs(cfg_regs), .configured(configured), .data_ready(data_ready),
    .done(done), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor; done must coincide with data_ready low and miso back at 0.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (data_ready !== 1'b0 || miso !== 1'b0) done_side_bad++;
    end
    if (abort) abort_cnt++;
    if (done && abort) both_cnt++;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic xfer_bit(input logic o, output logic i);
    mosi = o;
    tick(5);
    sclk = 1'b1;
    i = miso;
    tick(5);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic d;
    ss_n = 1'b0;
    tick(5);
    for (int k = 7; k > 7 - n; k--) xfer_bit(b[k], d);
    tick(6);
    ss_n = 1'b1;
    tick(6);
  endtask

  task automatic read_bits(input int n, output logic [31:0] v);
    logic b;
    v = '0;
    ss_n = 1'b0;
    tick(5);
    for (int k = 0; k < n; k++) begin
      xfer_bit(1'b0, b);
      v = {v[30:0], b};
    end
    tick(6);
  endtask

  task automatic apply_stimulus_load(input logic [1:0] sel);
    ch_sel = sel;
    load_en = 1'b1;
    tick(1);
    load_en = 1'b0;
  endtask

  function automatic logic [31:0] exp_frame(input logic [15:0] w, input logic p);
`ifdef SPI_SENSOR_LINK_PARITY_EN
    return {15'b0, w, p};
`else
    return {16'b0, w} | 32'(p & 1'b0);
`endif
  endfunction

  // Full read of a freshly loaded channel: data, exactly one done, data_ready cleared.
  task automatic read_and_check(input string tag, input logic [15:0] w, input logic p);
    logic [31:0] v;
    int d0, a0;
    d0 = done_cnt;
    a0 = abort_cnt;
    read_bits(FRAME, v);
    ss_n = 1'b1;
    tick(6);
    check_output({tag, "_data"}, 64'(v), 64'(exp_frame(w, p)));
    check_output({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    check_output({tag, "_abort"}, 64'(abort_cnt - a0), 64'd0);
    check_output({tag, "_ready_clr"}, 64'(data_ready), 64'd0);
  endtask

  initial begin
    logic [31:0] v;
    int d0, a0;
    rst = 1'b1; load_en = 1'b0; cfg_rearm = 1'b0; sclk = 1'b0; ss_n = 1'b1;
    mosi = 1'b0; ch_sel = '0; ch_data = 48'h5E0D_3C5A_0F0F;
    tick(3);
    check_output("rst_cfg_regs", 64'(cfg_regs), 64'h0);
    check_output("rst_flags", {60'h0, configured, data_ready, done, abort}, 64'h0);
    check_output("rst_miso", 64'(miso), 64'h0);
    rst = 1'b0;
    tick(3);

    apply_stimulus_load(2'd0);
    check_output("cfg_load_ignored", 64'(data_ready), 64'd0);

    send_bits(8'h55, 8);
    send_bits(8'h0F, 8);
    send_bits(8'h81, 8);
    check_output("cfg_not_yet", 64'(configured), 64'd0);
    send_bits(8'h05, 8);
    check_output("cfg_configured", 64'(configured), 64'd1);
    check_output("cfg_regs", 64'(cfg_regs), 64'h0581_0F55);
    check_output("cfg_no_abort", 64'(abort_cnt), 64'd0);
    check_output("idle_miso", 64'(miso), 64'd0);

    apply_stimulus_load(2'd0);
    check_output("ch0_ready", 64'(data_ready), 64'd1);
    ch_data[15:0] = 16'hFFFF;
    read_and_check("ch0", 16'h0F0F, 1'b0);
    ch_data[15:0] = 16'h0F0F;

    apply_stimulus_load(2'd1);
    check_output("ch1_ready", 64'(data_ready), 64'd1);
    read_and_check("ch1", 16'h3C5A, 1'b0);
    apply_stimulus_load(2'd2);
    read_and_check("ch2", 16'h5E0D, 1'b0);
    apply_stimulus_load(2'd3);
    check_output("ch3_ignored", 64'(data_ready), 64'd0);

    ch_data[15:0] = 16'h8001;
    apply_stimulus_load(2'd0);
    check_output("msb_miso", 64'(miso), 64'd1);
    read_and_check("ch0_8001", 16'h8001, 1'b0);

    d0 = done_cnt;
    a0 = abort_cnt;
    apply_stimulus_load(2'd1);
    read_bits(7, v);
    check_output("abort_partial_bits", 64'(v), 64'h1E);
    ss_n = 1'b1;
    tick(6);
    check_output("abort_pulse", 64'(abort_cnt - a0), 64'd1);
    check_output("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check_output("abort_ready_clr", 64'(data_ready), 64'd0);
    apply_stimulus_load(2'd1);
    read_and_check("after_abort", 16'h3C5A, 1'b0);

    ch_data[15:0] = 16'h0F0E;
    apply_stimulus_load(2'd0);
    d0 = done_cnt;
    read_bits(FRAME - 1, v);
    check_output("last_bit_no_done", 64'(done_cnt - d0), 64'd0);
    check_output("last_bit_ready", 64'(data_ready), 64'd1);
    xfer_bit(1'b0, v[31]);
    tick(6);
    check_output("last_bit_value", 64'(v[31]), (FRAME == 17) ? 64'd1 : 64'd0);
    check_output("last_bit_done", 64'(done_cnt - d0), 64'd1);
    ss_n = 1'b1;
    tick(6);
    ch_data[15:0] = 16'h0F0F;
    apply_stimulus_load(2'd0);
    read_and_check("par_0f0f", 16'h0F0F, 1'b0);

    cfg_rearm = 1'b1;
    load_en = 1'b1;
    ch_sel = 2'd0;
    tick(1);
    cfg_rearm = 1'b0;
    load_en = 1'b0;
    tick(2);
    check_output("rearm_flags", {62'h0, configured, data_ready}, 64'h0);
    check_output("rearm_keeps_regs", 64'(cfg_regs), 64'h0581_0F55);
    a0 = abort_cnt;
    send_bits(8'h11, 8);
    send_bits(8'hFF, 3);
    check_output("cfg_abort_pulse", 64'(abort_cnt - a0), 64'd1);
    send_bits(8'hA5, 8);
    check_output("cfg_abort_word1", 64'(cfg_regs), 64'h0581_A511);
    check_output("cfg_abort_not_cfgd", 64'(configured), 64'd0);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    check_output("recfg_regs", 64'(cfg_regs), 64'h3322_A511);
    check_output("recfg_configured", 64'(configured), 64'd1);

    check_output("done_side_effects", 64'(done_side_bad), 64'd0);
    check_output("done_abort_overlap", 64'(both_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
